base_window_ctrl: RTL and testbench
===================================

Name: base_window_ctrl

Overview:
- Sequencer for the 2-bit-per-base window shift register (B bases, 2*B bits) in the alignment datapath.
- Accepts a stream of nucleotide codes over a valid/ready handshake and drives the shift register's en/dir/in/clear controls.
- Fills the register with an initial B-base window, then slides it one base at a time, and presents each complete window to the downstream comparator over a valid/ready handshake with its position index.

Parameters:
- B, 4, window length in bases; must match the shift register's B; must be at least 2.
- POS_W, 16, width of the window position index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new sequence; ignored while busy=1.
- dir_cfg  in  1  shift direction, latched on an accepted start.
- s_valid  in  1  base stream valid.
- s_base  in  2  base code (A=00, C=01, G=10, T=11).
- s_last  in  1  marks the final base of the sequence; qualified by s_valid&&s_ready.
- s_ready  out  1  controller accepts a base this cycle.
- sr_en  out  1  shift-register enable.
- sr_dir  out  1  shift-register direction (the latched dir_cfg).
- sr_in  out  2  base inserted into the shift register.
- sr_clear  out  1  synchronous clear request to the shift register.
- win_valid  out  1  shift-register contents hold a complete window.
- win_ready  in  1  downstream accepts the window.
- win_pos  out  POS_W  0-based index of the presented window.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.
- err_short  out  1  sticky flag: sequence ended with fewer than B bases; cleared by the next accepted start.

Behaviour:
- States are IDLE, CLEAR, FILL, WAIT_WIN and DONE.
- Reset:
  - state=IDLE.
  - All outputs 0: s_ready, sr_en, sr_clear, win_valid, done, err_short, win_pos, sr_dir.
  - Internal counters and the last_seen flag cleared.
  - Reset takes effect mid-operation with no drain; the partially loaded window is discarded.
- IDLE:
  - On start: latch dir_cfg into sr_dir, clear err_short, zero win_pos, set need=B, clear last_seen, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - sr_clear=1, s_ready=0.
  - Next state is FILL.
- FILL:
  - s_ready=1.
  - sr_en=s_valid, sr_in=s_base, both combinational in the same cycle, so the register updates on the accepting edge.
  - Each accepted base decrements need.
  - If the accepted base has s_last=1, set last_seen.
  - Accept with need==1 goes to WAIT_WIN.
  - Accept of s_last with need>1: only possible in the initial fill. Set err_short and go to DONE; no window is emitted.
- WAIT_WIN:
  - win_valid=1, s_ready=0, sr_en=0.
  - The window is stable and aligned with the shift-register output on the first WAIT_WIN cycle.
  - On win_valid&&win_ready: win_pos increments (wraps modulo 2^POS_W).
    - If last_seen=1, go to DONE.
    - Otherwise set need=1 and go to FILL to slide one base.
  - win_valid holds with no timeout until accepted.
- DONE (1 cycle):
  - done=1.
  - Next state is IDLE.
- sr_en is never asserted outside FILL, and sr_clear only in CLEAR.
- Throughput: the first window arrives B+1 cycles after start at the earliest (1 CLEAR cycle + B FILL cycles). After that, at most one window every 2 cycles.
- A start pulse while busy is dropped with no side effects.
- s_last on the B-th base of the initial fill: one window at pos 0, then DONE.
- need counter width is $clog2(B+1).

Decomposition:
- Shared package alignment_pkg holds:
  - Base code localparams BASE_A/C/G/T.
  - The state enum for this block.
  - The convention that dir value 1 matches the shift register's dir=1 branch.
- No sub-module. The FSM, need counter and position counter live in a single module; the shift register is instantiated beside it at the parent level.

Test Plan:
- B=4, start, stream A,C,G,T(last) with s_valid held high, win_ready=1:
  - sr_en high for 4 cycles with sr_in = 00,01,10,11.
  - win_valid rises in the cycle after the 4th accept with win_pos=0.
  - done pulses 1 cycle after the window handshake.
  - err_short=0.
- Stream 6 bases, last=T on the 6th, win_ready=1:
  - Exactly 3 windows with win_pos=0,1,2.
  - Each slide is one sr_en pulse.
  - s_ready is 0 on every WAIT_WIN cycle.
- win_ready held 0 for 5 cycles after the first window:
  - win_valid stays 1, s_ready=0, sr_en=0 throughout.
  - win_pos is unchanged and the shift-register contents are unchanged.
- Stream A,C(last) with B=4:
  - err_short=1, no win_valid, done pulse.
  - The next start clears err_short.
- Assert reset during FILL after 2 bases:
  - Next cycle state=IDLE and all outputs 0.
  - A following start produces sr_clear for 1 cycle, then a fresh fill that starts at win_pos=0.
- Pulse start while busy, and use s_valid gaps in FILL:
  - The extra start has no effect.
  - sr_en follows s_valid exactly, and window content matches the accepted bases only.

Source files
------------

// File: rtl/alignment_pkg.sv
// alignment_pkg: definitions shared by the alignment datapath blocks.
//   BASE_A/C/G/T  : 2-bit nucleotide codes carried on the base stream
//   SR_DIR_1      : sr_dir value that selects the shift register's dir=1 branch
//   bwc_state_t   : base_window_ctrl sequencer states
package alignment_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    // dir_cfg/sr_dir are passed straight through: a 1 here means the shift
    // register takes its dir=1 branch, with no inversion anywhere in between.
    localparam logic SR_DIR_1 = 1'b1;

    typedef enum logic [2:0] {
        BWC_IDLE,
        BWC_CLEAR,
        BWC_FILL,
        BWC_WAIT_WIN,
        BWC_DONE
    } bwc_state_t;

endpackage

// File: rtl/base_window_ctrl.sv
// base_window_ctrl: sequencer for the 2*B-bit base window shift register.
// Clears the register, fills it with B bases from the stream, then presents
// each complete window downstream and slides in one base per window.
//   clk, reset          : clock, synchronous active-high reset
//   start, dir_cfg      : begin a sequence (ignored while busy), direction
//   s_valid/s_ready     : base stream handshake; s_base code, s_last marker
//   sr_en/sr_dir/sr_in  : shift register controls; sr_clear sync clear
//   win_valid/win_ready : window handshake; win_pos = 0-based window index
//   busy, done          : not idle, one-cycle end-of-sequence pulse
//   err_short           : sticky, sequence ended with fewer than B bases
module base_window_ctrl
    import alignment_pkg::*;
#(
    parameter int B     = 4,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir_cfg,
    input  logic             s_valid,
    input  logic [1:0]       s_base,
    input  logic             s_last,
    output logic             s_ready,
    output logic             sr_en,
    output logic             sr_dir,
    output logic [1:0]       sr_in,
    output logic             sr_clear,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [POS_W-1:0] win_pos,
    output logic             busy,
    output logic             done,
    output logic             err_short
);

    localparam int NEED_W = $clog2(B + 1);

    bwc_state_t        state, state_nx;
    logic [NEED_W-1:0] need;
    logic              last_seen;

    wire fill_acc = (state == BWC_FILL) && s_valid;
    wire win_acc  = (state == BWC_WAIT_WIN) && win_ready;

    // State register plus the counters/flags it sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BWC_IDLE;
            need      <= '0;
            last_seen <= 1'b0;
            sr_dir    <= 1'b0;
            err_short <= 1'b0;
            win_pos   <= '0;
        end else begin
            state <= state_nx;
            if (state == BWC_IDLE && start) begin
                sr_dir    <= dir_cfg;
                err_short <= 1'b0;
                win_pos   <= '0;
                need      <= NEED_W'(B);
                last_seen <= 1'b0;
            end
            if (fill_acc) begin
                need <= need - NEED_W'(1);
                if (s_last) last_seen <= 1'b1;
                // Only reachable in the initial fill: slides always run with need==1.
                if (s_last && need != NEED_W'(1)) err_short <= 1'b1;
            end
            if (win_acc) begin
                win_pos <= win_pos + POS_W'(1);
                if (!last_seen) need <= NEED_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BWC_IDLE:     if (start) state_nx = BWC_CLEAR;
            BWC_CLEAR:    state_nx = BWC_FILL;
            BWC_FILL: begin
                if (s_valid) begin
                    if (need == NEED_W'(1)) state_nx = BWC_WAIT_WIN;
                    else if (s_last)        state_nx = BWC_DONE;
                end
            end
            BWC_WAIT_WIN: if (win_ready) state_nx = last_seen ? BWC_DONE : BWC_FILL;
            BWC_DONE:     state_nx = BWC_IDLE;
            default:      state_nx = BWC_IDLE;
        endcase
    end

    // The base path is combinational so the register shifts on the accepting edge.
    always_comb begin
        s_ready   = (state == BWC_FILL);
        sr_en     = fill_acc;
        sr_in     = fill_acc ? s_base : BASE_A;
        sr_clear  = (state == BWC_CLEAR);
        win_valid = (state == BWC_WAIT_WIN);
        done      = (state == BWC_DONE);
        busy      = (state != BWC_IDLE);
    end

endmodule

// File: tb/tb_base_window_ctrl.sv
// Testbench for base_window_ctrl: directed sequences plus randomized runs,
// checked against sliding-window expectations computed from the base list.
module tb_base_window_ctrl;

    localparam int B     = 4;
    localparam int POS_W = 16;

    logic             clk = 1'b0;
    logic             reset, start, dir_cfg, s_valid, s_last, win_ready;
    logic [1:0]       s_base;
    logic             s_ready, sr_en, sr_dir, sr_clear, win_valid, busy, done, err_short;
    logic [1:0]       sr_in;
    logic [POS_W-1:0] win_pos;

    base_window_ctrl #(.B(B), .POS_W(POS_W)) dut (
        .clk(clk), .reset(reset), .start(start), .dir_cfg(dir_cfg),
        .s_valid(s_valid), .s_base(s_base), .s_last(s_last), .s_ready(s_ready),
        .sr_en(sr_en), .sr_dir(sr_dir), .sr_in(sr_in), .sr_clear(sr_clear),
        .win_valid(win_valid), .win_ready(win_ready), .win_pos(win_pos),
        .busy(busy), .done(done), .err_short(err_short)
    );

    always #5 clk = ~clk;

    int         ncmp = 0;
    int         nfail = 0;
    logic [1:0] seq[$];   // bases of the sequence under test
    logic [1:0] tsr[$];   // neighbour shift register, oldest base first

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_seq(input int from);
        logic [31:0] w = '0;
        for (int i = 0; i < B; i++) w = (w << 2) | 32'(seq[from + i]);
        return w;
    endfunction

    function automatic logic [31:0] pack_tsr();
        logic [31:0] w = '0;
        for (int i = 0; i < tsr.size(); i++) w = (w << 2) | 32'(tsr[i]);
        return w;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_sr_en"}, sr_en, 0);
        chk({tag, "_sr_clear"}, sr_clear, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_short"}, err_short, 0);
        chk({tag, "_win_pos"}, win_pos, 0);
        chk({tag, "_sr_dir"}, sr_dir, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Run the sequence in seq[] from start to done. p_valid/p_ready are
    // percent chances per cycle; timed=1 expects full-throughput timing.
    task automatic run_seq(input bit dir, input int p_valid, input int p_ready,
                           input bit stall5, input bit busy_start, input bit timed);
        int n = seq.size();
        int exp_wins = (n >= B) ? n - B + 1 : 0;
        int sent = 0, wins = 0, stall = 0, it = 0;
        bit fin = 0;
        @(negedge clk);
        start = 1; dir_cfg = dir; s_valid = 0; win_ready = 0; s_last = 0;
        @(negedge clk);
        start = 0; dir_cfg = ~dir;  // must already be latched
        #1;
        chk("clear_sr_clear", sr_clear, 1);
        chk("clear_s_ready", s_ready, 0);
        chk("clear_busy", busy, 1);
        chk("clear_err_short", err_short, 0);
        chk("clear_win_pos", win_pos, 0);
        if (sr_clear) tsr.delete();
        while (!fin && it < 400) begin
            @(negedge clk);
            s_valid   = (sent < n) && ($urandom_range(99) < p_valid);
            s_base    = (sent < n) ? seq[sent] : 2'($urandom);
            s_last    = (sent == n - 1);
            win_ready = ($urandom_range(99) < p_ready);
            if (stall5 && wins == 0 && stall < 5) win_ready = 0;
            start     = busy_start && ($urandom_range(3) == 0);
            #1;
            chk("sr_en_follows", sr_en, s_ready & s_valid);
            chk("sr_dir", sr_dir, dir);
            chk("sr_clear_off", sr_clear, 0);
            chk("busy", busy, 1);
            if (sr_en) chk("sr_in", sr_in, s_base);
            if (stall5 && wins == 0 && stall > 0 && stall <= 5) chk("stall_hold", win_valid, 1);
            if (win_valid) begin
                if (stall5 && wins == 0 && stall < 5) stall++;
                chk("win_s_ready", s_ready, 0);
                chk("win_sr_en", sr_en, 0);
                chk("win_pos", win_pos, wins);
                chk("win_len", tsr.size(), B);
                chk("win_data", pack_tsr(), pack_seq(wins));
                if (timed && win_ready) chk("win_time", it, B + 2 * wins);
            end
            if (done) begin
                fin = 1;
                chk("n_windows", wins, exp_wins);
                chk("n_accepted", sent, n);
                chk("err_short", err_short, n < B);
                if (timed) chk("done_time", it, B + 2 * (exp_wins - 1) + 1);
            end
            if (sr_en) begin
                tsr.push_back(sr_in);
                if (tsr.size() > B) void'(tsr.pop_front());
            end
            if (s_ready && s_valid) sent++;
            if (win_valid && win_ready) wins++;
            it++;
        end
        start = 0; s_valid = 0; win_ready = 0; s_last = 0;
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_err_sticky", err_short, n < B);
    endtask

    task automatic rand_seq(input int n);
        seq.delete();
        for (int i = 0; i < n; i++) seq.push_back(2'($urandom));
    endtask

    initial begin
        reset = 1; start = 0; dir_cfg = 0; s_valid = 0; s_base = 0; s_last = 0; win_ready = 0;
        @(negedge clk); @(negedge clk); #1;
        chk_quiet("rst");
        reset = 0;

        // A,C,G,T(last) at full rate: one window at pos 0, exact timing.
        seq = '{2'b00, 2'b01, 2'b10, 2'b11};
        run_seq(0, 100, 100, 0, 0, 1);

        // Six bases at full rate: three windows, one slide every 2 cycles.
        rand_seq(6); seq[5] = 2'b11;
        run_seq(1, 100, 100, 0, 0, 1);

        // First window held for 5 cycles.
        rand_seq(6);
        run_seq(0, 100, 100, 1, 0, 0);

        // Short sequence A,C(last), then a normal one clears err_short.
        seq = '{2'b00, 2'b01};
        run_seq(1, 100, 100, 0, 0, 0);
        rand_seq(5);
        run_seq(0, 100, 100, 0, 0, 0);

        // Reset mid-fill after 2 bases.
        @(negedge clk); start = 1; dir_cfg = 1;
        @(negedge clk); start = 0;
        @(negedge clk); s_valid = 1; s_base = 2'b10; s_last = 0;
        @(negedge clk); s_base = 2'b01;
        @(negedge clk); s_valid = 0; reset = 1;
        @(negedge clk); #1;
        chk_quiet("midrst");
        reset = 0;
        rand_seq(7);
        run_seq(0, 100, 100, 0, 0, 1);

        // Extra starts while busy, gaps on s_valid and win_ready.
        rand_seq(9);
        run_seq(1, 50, 60, 0, 1, 0);

        // Randomized sequences, lengths 1..10.
        for (int k = 0; k < 12; k++) begin
            rand_seq($urandom_range(10, 1));
            run_seq(1'($urandom), $urandom_range(100, 30), $urandom_range(100, 30),
                    1'($urandom), 1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
